// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns a shared 4:1 WIDTH-bit operand selector
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req[3:0]       level requests, one per requester
//   I0..I3         requester operands
//   gnt[3:0]       registered one-hot grant, zero when idle
//   s[1:0]         registered select code of current/last owner
//   busy           registered, high while a grant is held
//   o              I[s] while busy, else 0
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to cap each grant at HOLD_MAX
// cycles when another requester is waiting.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 5,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [3:0]       gnt,
  output logic [1:0]       s,
  output logic             busy,
  output logic [WIDTH-1:0] o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d, ptr_q, ptr_d, pick;
  logic       busy_q, busy_d, release_c;
`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       hold_max_c;
  assign hold_max_c = hold_q == 8'(HOLD_MAX - 1);
  // A capped owner is only displaced when someone else is actually waiting.
  assign release_c  = !req[s_q] || (hold_max_c && |(req & ~gnt_q));
`else
  logic hold_unused;
  assign hold_unused = |HOLD_MAX;
  assign release_c   = !req[s_q];
`endif
  // Scan downward so the requester closest to ptr (ptr, ptr+1, ...) wins last.
  always_comb begin
    pick = ptr_q;
    for (int k = 3; k >= 0; k--) if (req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d  = (state_q == IDLE) ? '0 : hold_q;
`endif
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        gnt_d   = 4'b1 << pick;
        s_d     = pick;
        busy_d  = 1'b1;
      end
    end else if (release_c) begin
      state_d = IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      ptr_d   = s_q + 2'd1;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    else if (!hold_max_c) hold_d = hold_q + 8'd1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end
  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = busy_q;
  always_comb o = !busy_q ? '0 : (s_q == 2'd0) ? I0 : (s_q == 2'd1) ? I1 : (s_q == 2'd2) ? I2 : I3;
endmodule
